sys_div_queue: RTL and testbench

SYS_DIV_QUEUE -- requirements
Module: sys_div_queue

---
 rtl/sys_div_pkg.sv | 24 ++
 rtl/sys_div_fifo.sv | 50 +++++
 rtl/sys_div_queue.sv | 172 +++++++++++++++++
 tb/tb_sys_div_queue.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_div_pkg.sv
// Shared types for the divide request queue.
// State enum and FIFO entry layout used by sys_div_queue and sys_div_fifo.
package sys_div_pkg;

    localparam int MAX_NUM = 32;
    localparam int MAX_DIV = 32;
    localparam int MAX_TAG = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    // Fields are sized for the widest configuration; narrower builds
    // leave the upper bits at zero and synthesis trims them.
    typedef struct packed {
        logic [MAX_NUM-1:0] num;
        logic [MAX_DIV-1:0] div;
        logic [MAX_TAG-1:0] tag;
    } entry_t;

endpackage

// File: rtl/sys_div_fifo.sv
// Request FIFO: DEPTH entries of WIDTH bits, first-word fall-through.
// Ports: clk, reset (sync, active-high), push/pop, data_in/data_out, full/empty.
module sys_div_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/sys_div_queue.sv
// Queues divide requests and feeds them one at a time to an iterative divider.
// Ports: in_* request handshake, dv_* divider side, out_* response handshake.
// Option: SYS_DIVQ_DZ_BYPASS_EN answers zero divisors locally (out_dz=1).
module sys_div_queue
    import sys_div_pkg::*;
#(
    parameter int NB_NUM = 16,
    parameter int NB_DIV = 16,
    parameter int DEPTH  = 4,
    parameter int NB_TAG = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NB_NUM-1:0] in_num,
    input  logic [NB_DIV-1:0] in_div,
    input  logic [NB_TAG-1:0] in_tag,
    output logic              dv_start,
    input  logic              dv_busy,
    output logic [NB_NUM-1:0] dv_num,
    output logic [NB_DIV-1:0] dv_div,
    input  logic [NB_NUM-1:0] dv_result,
    input  logic [NB_DIV-1:0] dv_remainder,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NB_NUM-1:0] out_result,
    output logic [NB_DIV-1:0] out_remainder,
    output logic [NB_TAG-1:0] out_tag,
    output logic              out_dz
);

`ifdef SYS_DIVQ_DZ_BYPASS_EN
    localparam bit DZ_BYPASS = 1'b1;
`else
    localparam bit DZ_BYPASS = 1'b0;
`endif

    state_t state;
    state_t state_next;

    entry_t push_e;
    entry_t head_e;
    logic   full;
    logic   empty;
    logic   pop;
    logic   unused_head;

    logic [NB_NUM-1:0] head_num;
    logic [NB_DIV-1:0] head_div;
    logic [NB_TAG-1:0] head_tag;
    logic              head_dz;

    logic [NB_TAG-1:0] tag_q;
    logic              wait_first;
    logic              capture;
    logic              dz_q;

    always_comb begin
        push_e = '0;
        push_e.num[NB_NUM-1:0] = in_num;
        push_e.div[NB_DIV-1:0] = in_div;
        push_e.tag[NB_TAG-1:0] = in_tag;
    end

    sys_div_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .pop      (pop),
        .data_in  (push_e),
        .data_out (head_e),
        .full     (full),
        .empty    (empty)
    );

    assign in_ready    = !full;
    assign head_num    = head_e.num[NB_NUM-1:0];
    assign head_div    = head_e.div[NB_DIV-1:0];
    assign head_tag    = head_e.tag[NB_TAG-1:0];
    assign unused_head = ^head_e;
    assign head_dz     = DZ_BYPASS && (head_div == '0);

    // The first WAIT cycle is skipped: busy may not yet reflect this start.
    assign capture = (state == WAIT) && !wait_first && !dv_busy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!empty) state_next = head_dz ? HOLD : ISSUE;
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (capture) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (empty)        state_next = IDLE;
                    else if (head_dz) state_next = HOLD;
                    else              state_next = ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dv_start  = 1'b0;
        out_valid = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            ISSUE:   dv_start = 1'b1;
            WAIT:    ;
            HOLD: begin
                out_valid = 1'b1;
                pop       = out_ready && !empty;
            end
            default: ;
        endcase
    end

    // Operand and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dv_num        <= '0;
            dv_div        <= '0;
            tag_q         <= '0;
            wait_first    <= 1'b0;
            out_result    <= '0;
            out_remainder <= '0;
            out_tag       <= '0;
            dz_q          <= 1'b0;
        end else begin
            wait_first <= (state == ISSUE);
            if (pop) begin
                dv_num <= head_num;
                dv_div <= head_div;
                tag_q  <= head_tag;
                if (head_dz) begin
                    out_result    <= '1;
                    out_remainder <= '0;
                    out_tag       <= head_tag;
                    dz_q          <= 1'b1;
                end
            end
            if (capture) begin
                out_result    <= dv_result;
                out_remainder <= dv_remainder;
                out_tag       <= tag_q;
                dz_q          <= 1'b0;
            end
        end
    end

    assign out_dz = DZ_BYPASS ? dz_q : 1'b0;

endmodule

// File: tb/tb_sys_div_queue.sv
// Scoreboard bench for sys_div_queue with a behavioural divider model.
// Expected responses come from plain / and % on the accepted requests.
module tb_sys_div_queue;

    localparam int NB_NUM = 16;
    localparam int NB_DIV = 16;
    localparam int DEPTH  = 4;
    localparam int NB_TAG = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NB_NUM-1:0] in_num;
    logic [NB_DIV-1:0] in_div;
    logic [NB_TAG-1:0] in_tag;
    logic              dv_start;
    logic              dv_busy = 1'b0;
    logic [NB_NUM-1:0] dv_num;
    logic [NB_DIV-1:0] dv_div;
    logic [NB_NUM-1:0] dv_result = '0;
    logic [NB_DIV-1:0] dv_remainder = '0;
    logic              out_valid;
    logic              out_ready;
    logic [NB_NUM-1:0] out_result;
    logic [NB_DIV-1:0] out_remainder;
    logic [NB_TAG-1:0] out_tag;
    logic              out_dz;

    sys_div_queue #(
        .NB_NUM (NB_NUM),
        .NB_DIV (NB_DIV),
        .DEPTH  (DEPTH),
        .NB_TAG (NB_TAG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_num        (in_num),
        .in_div        (in_div),
        .in_tag        (in_tag),
        .dv_start      (dv_start),
        .dv_busy       (dv_busy),
        .dv_num        (dv_num),
        .dv_div        (dv_div),
        .dv_result     (dv_result),
        .dv_remainder  (dv_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_dz        (out_dz)
    );

    typedef struct {
        logic [NB_NUM-1:0] q;
        logic [NB_DIV-1:0] r;
        logic [NB_TAG-1:0] t;
        logic              dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   resp_cnt = 0;
    int   starts = 0;
    int   cyc = 0;
    int   lat = 16;
    bit   rand_lat = 0;
    bit   chk_stable = 1;

    logic [NB_NUM-1:0] last_res;
    logic [NB_DIV-1:0] last_rem;
    logic [NB_TAG-1:0] last_tag;
    logic              last_dz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ref_model(logic [NB_NUM-1:0] n,
                                       logic [NB_DIV-1:0] d,
                                       logic [NB_TAG-1:0] t);
        exp_t e;
        e.t = t;
        e.dz = 1'b0;
        if (d == 0) begin
            e.q = '1;
`ifdef SYS_DIVQ_DZ_BYPASS_EN
            e.r = '0;
            e.dz = 1'b1;
`else
            e.r = NB_DIV'(n);
`endif
        end else begin
            e.q = n / d;
            e.r = n % d;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Divider model: busy for a number of cycles, result on busy fall.
    int                cnt = 0;
    logic [NB_NUM-1:0] mn = '0;
    logic [NB_DIV-1:0] md = '0;

    always @(posedge clk) begin
        if (dv_start) begin
            mn        <= dv_num;
            md        <= dv_div;
            cnt       <= rand_lat ? $urandom_range(1, 6) : lat;
            dv_busy   <= 1'b1;
            dv_result <= NB_NUM'($urandom);
        end else if (dv_busy) begin
            if (cnt > 1) begin
                cnt <= cnt - 1;
                dv_result <= NB_NUM'($urandom);
            end else begin
                dv_busy      <= 1'b0;
                dv_result    <= (md == 0) ? '1 : mn / NB_NUM'(md);
                dv_remainder <= (md == 0) ? NB_DIV'(mn) : NB_DIV'(mn % md);
            end
        end
    end

    // Request capture into the scoreboard
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready)
            sb.push_back(ref_model(in_num, in_div, in_tag));
        if (dv_start) starts++;
    end

    // Response monitor
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            resp_cnt++;
            last_res = out_result;
            last_rem = out_remainder;
            last_tag = out_tag;
            last_dz  = out_dz;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp: unexpected response q=%0d r=%0d",
                         out_result, out_remainder);
            end else begin
                e = sb.pop_front();
                if (out_result !== e.q || out_remainder !== e.r ||
                    out_tag !== e.t || out_dz !== e.dz) begin
                    errors++;
                    $display("FAIL resp: got q=%0d r=%0d t=%0d dz=%0d want q=%0d r=%0d t=%0d dz=%0d",
                             out_result, out_remainder, out_tag, out_dz,
                             e.q, e.r, e.t, e.dz);
                end
            end
        end
    end

    // Operands must hold while the divider works
    always @(negedge clk) begin
        if (chk_stable && dv_busy) begin
            checks++;
            if (dv_num !== mn || dv_div !== md) begin
                errors++;
                $display("FAIL operand_hold: got %0d/%0d want %0d/%0d",
                         dv_num, dv_div, mn, md);
            end
        end
    end

    task automatic send(logic [NB_NUM-1:0] n, logic [NB_DIV-1:0] d,
                        logic [NB_TAG-1:0] t);
        bit ok = 0;
        in_num   = n;
        in_div   = d;
        in_tag   = t;
        in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_resp(int target, int budget);
        for (int i = 0; i < budget; i++) begin
            if (resp_cnt >= target) break;
            @(negedge clk);
        end
        chk("resp_timeout", 32'(resp_cnt >= target), 32'd1);
    endtask

    initial begin
        int s0;
        int r0;
        int t0;
        bit done;
        logic [NB_NUM-1:0] h_res;
        logic [NB_DIV-1:0] h_rem;
        logic [NB_TAG-1:0] h_tag;

        reset = 1'b1;
        in_valid = 1'b0;
        in_num = '0;
        in_div = '0;
        in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dv_start", 32'(dv_start), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_remainder", 32'(out_remainder), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_dz", 32'(out_dz), 32'd0);
        @(posedge clk);
        #1;

        // Single request through a 16-cycle divider
        out_ready = 1'b1;
        lat = 16;
        send(16'd100, 16'd7, 4'd3);
        wait_resp(1, 100);
        chk("single_result", 32'(last_res), 32'd14);
        chk("single_rem", 32'(last_rem), 32'd2);
        chk("single_tag", 32'(last_tag), 32'd3);
        chk("single_dz", 32'(last_dz), 32'd0);

        // Five back-to-back requests with the output stalled
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        lat = 4;
        r0 = resp_cnt;
        t0 = cyc;
        for (int i = 0; i < 5; i++)
            send(NB_NUM'(200 + 17 * i), NB_DIV'(3 + i), NB_TAG'(i + 8));
        chk("burst_cycles", 32'(cyc - t0), 32'd5);
        @(negedge clk);
        chk("burst_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_resp(r0 + 5, 300);

        // Long stall in HOLD with more work queued
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        lat = 3;
        r0 = resp_cnt;
        send(16'd1000, 16'd33, 4'd1);
        send(16'd999, 16'd10, 4'd2);
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        chk("hold_reached", 32'(out_valid), 32'd1);
        h_res = out_result;
        h_rem = out_remainder;
        h_tag = out_tag;
        s0 = starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_stable",
                32'({out_valid, out_result, out_remainder, out_tag}),
                32'({1'b1, h_res, h_rem, h_tag}));
        end
        chk("hold_no_start", 32'(starts - s0), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_resp(r0 + 2, 100);

        // Zero divisor
        @(posedge clk);
        #1;
        r0 = resp_cnt;
        s0 = starts;
        send(16'd55, 16'd0, 4'd5);
        wait_resp(r0 + 1, 100);
        chk("dz_result", 32'(last_res), 32'hFFFF);
`ifdef SYS_DIVQ_DZ_BYPASS_EN
        chk("dz_starts", 32'(starts - s0), 32'd0);
        chk("dz_flag", 32'(last_dz), 32'd1);
        chk("dz_rem", 32'(last_rem), 32'd0);
`else
        chk("dz_starts", 32'(starts - s0), 32'd1);
        chk("dz_flag", 32'(last_dz), 32'd0);
`endif

        // Reset during WAIT with requests still queued
        @(posedge clk);
        #1;
        lat = 10;
        s0 = starts;
        send(16'd9, 16'd3, 4'd1);
        send(16'd8, 16'd2, 4'd2);
        send(16'd7, 16'd1, 4'd3);
        for (int i = 0; i < 50; i++) begin
            if (starts > s0) break;
            @(negedge clk);
        end
        chk("rst_mid_started", 32'(starts > s0), 32'd1);
        @(posedge clk);
        #1;
        chk_stable = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        s0 = starts;
        r0 = resp_cnt;
        repeat (25) @(negedge clk);
        chk("rst_mid_no_start", 32'(starts - s0), 32'd0);
        chk("rst_mid_no_resp", 32'(resp_cnt - r0), 32'd0);
        chk("rst_mid_busy_gone", 32'(dv_busy), 32'd0);

        // Randomized traffic with random output back-pressure
        @(posedge clk);
        #1;
        chk_stable = 1;
        rand_lat = 1;
        r0 = resp_cnt;
        done = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [NB_DIV-1:0] d;
                    if ($urandom_range(0, 3) == 0)
                        d = NB_DIV'($urandom_range(0, 15));
                    else
                        d = NB_DIV'($urandom);
                    send(NB_NUM'($urandom), d, NB_TAG'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_resp(r0 + 1000, 2000);
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
